// File: rtl/scarv_cop_pmul_engine.sv
// Bit-serial packed multiplier: 1/2/4/8/16 unsigned lanes, integer or carry-less,
// answering a start/done handshake with the low or high half of each lane product.
module scarv_cop_pmul_engine (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        start,
  output logic        done,
  output logic        busy,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  pw,
  input  logic        high,
  input  logic        ncarry,
  output logic [31:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic [2:0]  r_pw;
  logic        r_high;
  logic        r_ncarry;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic        r_done;
  logic        r_busy;

  logic [4:0][63:0] w_step;
  logic [4:0][31:0] w_pack;
  logic [63:0]      w_acc_nxt;
  logic [31:0]      w_res_nxt;
  logic             w_last;
  logic             w_pw_legal;

  // One candidate next-accumulator per pack width; r_pw picks which is used.
  for (genvar gp = 0; gp < 5; gp++) begin : g_w
    localparam int W = 32 >> gp;
    localparam int L = 32 / W;
    for (genvar gl = 0; gl < L; gl++) begin : g_l
      logic [2*W-1:0] w_acc_l;
      logic [2*W-1:0] w_add;
      logic [2*W-1:0] w_new;
      logic [W-1:0]   w_a_l;
      logic [W-1:0]   w_b_l;
      logic [W-1:0]   w_mask;
      logic           w_bk;

      assign w_acc_l = r_acc[2*W*gl +: 2*W];
      assign w_a_l   = r_a[W*gl +: W];
      assign w_b_l   = r_b[W*gl +: W];
      assign w_mask  = {{(W-1){1'b0}}, 1'b1} << r_cnt;
      assign w_bk    = |(w_b_l & w_mask);
      assign w_add   = {{W{1'b0}}, w_a_l} << r_cnt;
      assign w_new   = !w_bk    ? w_acc_l :
                       r_ncarry ? (w_acc_l ^ w_add) : (w_acc_l + w_add);

      assign w_step[gp][2*W*gl +: 2*W] = w_new;
      assign w_pack[gp][W*gl +: W]     = r_high ? w_new[2*W-1:W] : w_new[W-1:0];
    end
  end

  always_comb begin
    w_acc_nxt = 64'd0;
    w_res_nxt = 32'd0;
    w_last    = 1'b1;
    case (r_pw)
      3'd0: begin w_acc_nxt = w_step[0]; w_res_nxt = w_pack[0]; w_last = (r_cnt == 5'd31); end
      3'd1: begin w_acc_nxt = w_step[1]; w_res_nxt = w_pack[1]; w_last = (r_cnt == 5'd15); end
      3'd2: begin w_acc_nxt = w_step[2]; w_res_nxt = w_pack[2]; w_last = (r_cnt == 5'd7);  end
      3'd3: begin w_acc_nxt = w_step[3]; w_res_nxt = w_pack[3]; w_last = (r_cnt == 5'd3);  end
      3'd4: begin w_acc_nxt = w_step[4]; w_res_nxt = w_pack[4]; w_last = (r_cnt == 5'd1);  end
      default: ;
    endcase
  end

  assign w_pw_legal = (pw <= 3'd4);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state  <= S_IDLE;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_pw     <= 3'd0;
      r_high   <= 1'b0;
      r_ncarry <= 1'b0;
      r_cnt    <= 5'd0;
      r_acc    <= 64'd0;
      r_result <= 32'd0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_pw_legal) begin
              r_a      <= a;
              r_b      <= b;
              r_pw     <= pw;
              r_high   <= high;
              r_ncarry <= ncarry;
              r_acc    <= 64'd0;
              r_cnt    <= 5'd0;
              r_busy   <= 1'b1;
              r_state  <= S_BUSY;
            end else begin
              r_result <= 32'd0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          // Dropping start mid-operation abandons it; result keeps its old value.
          if (!start) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            if (w_last) begin
              r_result <= w_res_nxt;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done   = r_done;
  assign busy   = r_busy;
  assign result = r_result;

endmodule

// File: tb/tb_scarv_cop_pmul_engine.sv
// Directed bench for scarv_cop_pmul_engine: hand-computed products and latencies.
module tb_scarv_cop_pmul_engine;

  logic        g_clk;
  logic        g_resetn;
  logic        start;
  logic        done;
  logic        busy;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  pw;
  logic        high;
  logic        ncarry;
  logic [31:0] result;

  int n_total;
  int n_bad;
  int n_overlap;

  scarv_cop_pmul_engine dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .start    (start),
    .done     (done),
    .busy     (busy),
    .a        (a),
    .b        (b),
    .pw       (pw),
    .high     (high),
    .ncarry   (ncarry),
    .result   (result)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  always @(negedge g_clk) if (done && busy) n_overlap++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Issue one request, scramble the inputs while busy, check latency and result.
  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [2:0] ipw, input logic ih, input logic inc,
                        input logic [31:0] exp_r, input int exp_lat);
    int lat;
    lat = -1;
    @(negedge g_clk);
    a = ia; b = ib; pw = ipw; high = ih; ncarry = inc; start = 1'b1;
    @(posedge g_clk);
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge g_clk);
      if (done) begin
        lat = c;
        start = 1'b0;
      end else if (c == 1) begin
        a = ~ia; b = ~ib; pw = 3'd4; high = ~ih; ncarry = ~inc;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_r);
    @(negedge g_clk);
    chk({tag, "_hold"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int seen;
    logic [31:0] prev;
    n_total = 0; n_bad = 0; n_overlap = 0;
    start = 0; a = 0; b = 0; pw = 0; high = 0; ncarry = 0;
    g_resetn = 0;
    #12;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    g_resetn = 1;

    run_op("w32_lo", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 32'h00000001, 33);
    run_op("w32_hi", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b0, 32'hFFFFFFFE, 33);
    run_op("w16_lo", 32'h0003FFFF, 32'h0005FFFF, 3'd1, 1'b0, 1'b0, 32'h000F0001, 17);
    run_op("w16_hi", 32'h0003FFFF, 32'h0005FFFF, 3'd1, 1'b1, 1'b0, 32'h0000FFFE, 17);
    run_op("clm_lo", 32'h00000003, 32'h00000003, 3'd0, 1'b0, 1'b1, 32'h00000005, 33);
    run_op("clm_hi", 32'h00000003, 32'h00000003, 3'd0, 1'b1, 1'b1, 32'h00000000, 33);
    run_op("int_lo", 32'h00000003, 32'h00000003, 3'd0, 1'b0, 1'b0, 32'h00000009, 33);
    run_op("w2_lo",  32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 1'b0, 1'b0, 32'h55555555, 3);
    run_op("w2_hi",  32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 1'b1, 1'b0, 32'hAAAAAAAA, 3);
    run_op("w4_lo",  32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 1'b0, 1'b0, 32'h11111111, 5);
    run_op("ill",    32'h12345678, 32'h9ABCDEF0, 3'd7, 1'b0, 1'b0, 32'h00000000, 1);
    run_op("w8_lo",  32'h02030405, 32'h03040506, 3'd2, 1'b0, 1'b0, 32'h060C141E, 9);

    // Abort: drop start in cycle 5; no done, result untouched.
    prev = result;
    @(negedge g_clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; pw = 3'd0; high = 1'b1; ncarry = 1'b0; start = 1'b1;
    @(posedge g_clk);
    for (int c = 1; c <= 5; c++) @(negedge g_clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge g_clk);
      if (done) seen++;
    end
    chk("abort_done", 32'(seen), 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_res", result, prev);
    run_op("after_abort", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b0, 32'hFFFFFFFE, 33);

    // Asynchronous reset at cycle 10 of an operation.
    @(negedge g_clk);
    a = 32'h00000003; b = 32'h00000003; pw = 3'd0; high = 1'b0; ncarry = 1'b0; start = 1'b1;
    @(posedge g_clk);
    for (int c = 1; c <= 10; c++) @(negedge g_clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 g_resetn = 1'b0;
    #1;
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_res", result, 32'd0);
    start = 1'b0;
    @(negedge g_clk);
    g_resetn = 1'b1;

    // Back-to-back: start held across done with new operands.
    @(negedge g_clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; pw = 3'd4; high = 1'b0; ncarry = 1'b0; start = 1'b1;
    @(posedge g_clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge g_clk);
      if (c == 3) begin
        chk("b2b_done1", {31'd0, done}, 32'd1);
        chk("b2b_res1", result, 32'h55555555);
        pw = 3'd3;
      end else if (c == 4) begin
        chk("b2b_idle", {31'd0, busy}, 32'd0);
      end else if (c == 5) begin
        chk("b2b_busy2", {31'd0, busy}, 32'd1);
      end else if (c == 9) begin
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_res2", result, 32'h11111111);
        start = 1'b0;
      end else begin
        chk($sformatf("b2b_nodone_c%0d", c), {31'd0, done}, 32'd0);
      end
    end

    chk("overlap", 32'(n_overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/scarv_cop_pmul_engine.md
Name: scarv_cop_pmul_engine

Overview:
Sequential packed multiplier. It is the responder side of the start/done multiply handshake issued by the packed-ALU for pmul.l, pmul.h, pclmul.l and pclmul.h. It splits a and b into 1/2/4/8/16 lanes selected by pw and multiplies all lanes in parallel, bit-serially, using integer or carry-less arithmetic. It returns either the low or the high half of each lane product, packed into 32 bits.

Parameters:
None; the datapath is fixed at 32 bits.

Ports:
g_clk     input   1   global clock, rising edge
g_resetn  input   1   asynchronous active-low reset
start     input   1   level request; held high by the initiator until done is seen
done      output  1   single-cycle pulse; result is valid in this cycle
busy      output  1   high while in BUSY state
a         input   32  LHS operand, sampled on capture
b         input   32  RHS operand, sampled on capture
pw        input   3   pack width: 000=32b, 001=16b, 010=8b, 011=4b, 100=2b; 101..111 illegal
high      input   1   1 selects the upper W bits of each 2W-bit lane product, 0 selects the lower W bits
ncarry    input   1   1 selects carry-less (XOR) accumulation
result    output  32  packed lane results

Behaviour:
- Reset, asynchronous on g_resetn low:
  - state goes to IDLE; done=0, busy=0, result=0.
  - Operand, mode, counter and accumulator registers are cleared.
  - Applies immediately, including mid-operation.
- States and transitions:
  - IDLE, start=1 and pw legal: capture a, b, pw, high and ncarry; clear the 64-bit accumulator and the counter; go to BUSY.
  - IDLE, start=1 and pw illegal: go to DONE with result forced to 0.
  - IDLE, start=0: stay in IDLE.
  - BUSY, start=1: perform one step per cycle (below). When counter = W-1, go to DONE; otherwise increment the counter.
  - BUSY, start=0: abort. Return to IDLE with no done pulse; result keeps its previous value.
  - DONE: done=1 for exactly one cycle; result is updated on entry. Always return to IDLE next cycle.
  - A start still high in the cycle after done is a new request and is captured.
- Step at counter k, applied to each lane l (lane width W = 32>>pw, L = 32/W lanes):
  - acc_l is the 2W-bit field of the accumulator at bits [2W*l +: 2W].
  - If b_l[k]=1: acc_l = acc_l + (zero-extended a_l << k) when ncarry=0, or acc_l XOR (a_l << k) when ncarry=1.
  - Lane adds are modulo 2^(2W). No carry crosses a lane boundary.
- Result packing: result[W*l +: W] = acc_l[2W-1:W] when high=1, else acc_l[W-1:0].
- Latency, with the capture cycle numbered 0:
  - BUSY occupies cycles 1..W; done is high in cycle W+1.
  - Totals: 33 cycles for 32b, 17 for 16b, 9 for 8b, 5 for 4b, 3 for 2b.
  - Illegal pw: done in cycle 1.
- Signed operation is not supported; all lanes are unsigned.
- result is held stable between done pulses and after an abort.
- The mode registers decouple the block from input changes. Changes on a, b, pw, high or ncarry during BUSY have no effect.
- busy=1 exactly in BUSY. done and busy are never high together.

Test Plan:
1. pw=000, a=b=0xFFFFFFFF:
   - high=0 -> result 0x00000001; high=1 -> result 0xFFFFFFFE.
   - done high in cycle 33 only.
2. pw=001, a=0x0003FFFF, b=0x0005FFFF:
   - low -> 0x000F0001; high -> 0x0000FFFE.
   - Lanes are independent with no carry leak; done in cycle 17.
3. Carry-less, pw=000, ncarry=1, a=b=0x00000003:
   - low -> 0x00000005, high -> 0x00000000.
   - Same operands with ncarry=0 -> low 0x00000009.
4. pw=100, a=b=0xFFFFFFFF:
   - low -> 0x55555555, high -> 0xAAAAAAAA; done in cycle 3.
   - pw=011, a=b=0xFFFFFFFF, low -> 0x11111111, done in cycle 5.
5. Abort and reset:
   - pw=000, drop start at cycle 5 -> IDLE, no done, result unchanged; a fresh start then completes correctly.
   - Assert g_resetn low at cycle 10 of an operation -> done=0, busy=0, result=0 with no clock edge needed.
6. Back-to-back and illegal pw:
   - Hold start high across done with new operands -> second op captured the cycle after done, done again W+1 cycles later.
   - pw=111 -> done in cycle 1 with result 0x00000000.
